// File: rtl/fa_response_checker.sv
// Response checker for the full-adder datapath: compares observed {cout,sum}
// against an internal golden sum, counts mismatches and tracks input coverage.
module fa_response_checker #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned NUM_VEC = 8,
    parameter int unsigned ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    input  logic [WIDTH-1:0]   obs_sum,
    input  logic               obs_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [15:0]        vec_count,
    output logic               cov_full,
    output logic               first_err_valid,
    output logic [2*WIDTH:0]   first_err_vec
);

    localparam int unsigned VEC_W = 2 * WIDTH + 1;
    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned NCOMB = 1 << VEC_W;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   vec_q, vec_d;
    logic [NCOMB-1:0]   cov_q, cov_d;
    logic               fev_q, fev_d;
    logic [VEC_W-1:0]   fe_q, fe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic [SUM_W-1:0]   exp_sum;
    logic [VEC_W-1:0]   vec_idx;
    logic               mismatch;

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= '0;
            vec_q   <= '0;
            cov_q   <= '0;
            fev_q   <= 1'b0;
            fe_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            cov_q   <= cov_d;
            fev_q   <= fev_d;
            fe_q    <= fe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state, golden compare and result update
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        vec_d    = vec_q;
        cov_d    = cov_q;
        fev_d    = fev_q;
        fe_d     = fe_q;
        pass_d   = pass_q;
        exp_sum  = SUM_W'(in_a) + SUM_W'(in_b) + SUM_W'(in_cin);
        vec_idx  = {in_a, in_b, in_cin};
        mismatch = ({obs_cout, obs_sum} != exp_sum);

        case (state_q)
            IDLE, REPORT: begin
                // A start in the same cycle as in_valid never checks that vector
                if (start) begin
                    err_d   = '0;
                    vec_d   = '0;
                    cov_d   = '0;
                    fev_d   = 1'b0;
                    fe_d    = '0;
                    pass_d  = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (in_valid) begin
                    vec_d          = vec_q + CNT_W'(1);
                    cov_d[vec_idx] = 1'b1;
                    if (mismatch) begin
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (!fev_q) begin
                            fev_d = 1'b1;
                            fe_d  = vec_idx;
                        end
                    end
                    if (vec_d == CNT_W'(NUM_VEC)) begin
                        state_d = REPORT;
                        pass_d  = (err_d == '0) && (&cov_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CHECK);
        done_d = (state_d == REPORT);
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign vec_count       = vec_q;
    assign cov_full        = &cov_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fe_q;

endmodule

// File: tb/tb_fa_response_checker.sv
// Scoreboard bench for fa_response_checker (WIDTH=1, NUM_VEC=8, ERR_W=2).
module tb_fa_response_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [0:0] in_a;
    logic [0:0] in_b;
    logic       in_cin;
    logic [0:0] obs_sum;
    logic       obs_cout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] err_count;
    logic [15:0] vec_count;
    logic       cov_full;
    logic       first_err_valid;
    logic [2:0] first_err_vec;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        pass;
        logic [1:0]  err;
        logic [15:0] vec;
        logic        cov;
        logic        fev;
        logic [2:0]  fe;
    } result_t;

    result_t exp_q[$];

    fa_response_checker #(.WIDTH(1), .NUM_VEC(8), .ERR_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .obs_sum(obs_sum), .obs_cout(obs_cout),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_count(vec_count), .cov_full(cov_full),
        .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] fa_model(input logic [2:0] v);
        return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    // Present one vector for one clock; mask flips bits of {cout,sum}
    task automatic send(input logic [2:0] v, input logic [1:0] mask);
        logic [1:0] r;
        r = fa_model(v) ^ mask;
        in_valid = 1'b1;
        in_a     = v[2];
        in_b     = v[1];
        in_cin   = v[0];
        obs_cout = r[1];
        obs_sum  = r[0];
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic result_t mk(input logic p, input logic [1:0] e, input logic c,
                                   input logic fv, input logic [2:0] f);
        result_t r;
        r.pass = p; r.err = e; r.vec = 16'd8; r.cov = c; r.fev = fv; r.fe = f;
        return r;
    endfunction

    // Monitor: pops an expected result on every rising edge of done
    initial begin
        logic    done_prev;
        result_t e;
        done_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pass", 32'(pass), 32'(e.pass));
                    check("sb_err_count", 32'(err_count), 32'(e.err));
                    check("sb_vec_count", 32'(vec_count), 32'(e.vec));
                    check("sb_cov_full", 32'(cov_full), 32'(e.cov));
                    check("sb_first_err_valid", 32'(first_err_valid), 32'(e.fev));
                    check("sb_first_err_vec", 32'(first_err_vec), 32'(e.fe));
                    check("sb_busy_low", 32'(busy), 32'd0);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; obs_sum = '0; obs_cout = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cov_full", 32'(cov_full), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // in_valid in IDLE is ignored
        send(3'b101, 2'b00);
        check("idle_valid_ignored", 32'(vec_count), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);

        // Exhaustive good run
        exp_q.push_back(mk(1'b1, 2'd0, 1'b1, 1'b0, 3'b000));
        pulse_start();
        check("run1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("run1_done_before_last", 32'(done), 32'd0);
            send(3'(i), 2'b00);
        end
        check("run1_done_latency", 32'(done), 32'd1);
        check("run1_pass", 32'(pass), 32'd1);
        tick();

        // Injected faults: cout forced 0 at 110, sum inverted at 111
        exp_q.push_back(mk(1'b0, 2'd2, 1'b1, 1'b1, 3'b110));
        pulse_start();
        check("run2_cleared", 32'(vec_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            send(3'(i), (i == 6) ? 2'b10 : ((i == 7) ? 2'b01 : 2'b00));
            if (i == 6) begin
                check("run2_err_after_110", 32'(err_count), 32'd1);
                check("run2_first_err_110", 32'(first_err_vec), 32'd6);
            end
        end
        tick();

        // Incomplete coverage: 000 twice, 111 never
        exp_q.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 3'b000));
        pulse_start();
        send(3'b000, 2'b00);
        for (int i = 0; i < 7; i++) send(3'(i), 2'b00);
        tick();

        // From REPORT: start with a bad vector in the same cycle (not checked),
        // then gapped valid with a start pulse mid-run
        exp_q.push_back(mk(1'b1, 2'd0, 1'b1, 1'b0, 3'b000));
        start = 1'b1;
        send(3'b111, 2'b11);
        start = 1'b0;
        check("gap_start_vec_unchecked", 32'(vec_count), 32'd0);
        check("gap_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 2'b00);
            if (i == 3) start = 1'b1;
            tick();
            start = 1'b0;
            if (i == 3) begin
                check("gap_mid_vec_count", 32'(vec_count), 32'd4);
                check("gap_mid_still_busy", 32'(busy), 32'd1);
            end
        end
        tick();

        // Saturation: every response wrong
        exp_q.push_back(mk(1'b0, 2'd3, 1'b1, 1'b1, 3'b000));
        pulse_start();
        for (int i = 0; i < 8; i++) send(3'(i), 2'b01);
        tick();

        // Async reset mid-run, between clock edges
        pulse_start();
        for (int i = 0; i < 4; i++) send(3'(i), 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_pass", 32'(pass), 32'd0);
        check("arst_err_count", 32'(err_count), 32'd0);
        check("arst_vec_count", 32'(vec_count), 32'd0);
        check("arst_cov_full", 32'(cov_full), 32'd0);
        check("arst_first_err", 32'({first_err_valid, first_err_vec}), 32'd0);
        #3;
        rst = 1'b0;
        tick();
        check("arst_idle_after", 32'(busy), 32'd0);

        exp_q.push_back(mk(1'b1, 2'd0, 1'b1, 1'b0, 3'b000));
        pulse_start();
        for (int i = 7; i >= 0; i--) send(3'(i), 2'b00);
        tick(); tick();
        #2;
        check("sb_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
